proc_param: RTL and testbench
=============================

Name: proc_param

Overview:
- Parametrised multi-cycle processor core: next generation of the 16-bit, 8-register MV/MVI/ADD/SUB processor.
- Data width and register count are generics. Adds AND, SLT and MVNZ, a zero flag and a done handshake.
- Instruction word arrives on ir and immediate data on din, both from the surrounding lab top or bench.
- The internal bus value is exported on q for observation.

Parameters:
- DATA_W, 16, width of registers, din, bus and q.
- NREGS, 8, number of general registers (power of two, 2..16).
- Derived localparam REG_AW = clog2(NREGS); IR_W = 3 + 2*REG_AW (9 at defaults).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  start request, sampled only in T0.
- ir  in  IR_W  instruction: [IR_W-1:IR_W-3] opcode, next REG_AW bits Rx, low REG_AW bits Ry.
- din  in  DATA_W  immediate operand for MVI, sampled in T1.
- q  out  DATA_W  current internal bus value (combinational mux).
- done  out  1  high for exactly the final cycle of each instruction (combinational from state).

Behaviour:
- Reset (async, high): state=T0; R0..R(NREGS-1), IR, A, G cleared to 0; Z=1. Outputs: q=0, done=0.
- Bus mux: Rn, din or G. When no source is selected, bus = 0.
- Register writes take effect on the rising edge that ends the cycle.
- Opcodes: 000 MV, 001 MVI, 010 ADD, 011 SUB, 100 AND, 101 SLT, 110 MVNZ, 111 reserved (NOP).
- State T0 (idle):
  - Bus = 0.
  - If run=1: IR <= ir, go to T1. Otherwise stay in T0.
- State T1:
  - MV: bus = Ry; Rx <= Ry; done=1; go to T0.
  - MVI: bus = din; Rx <= din; done=1; go to T0.
  - MVNZ: bus = Ry; if Z=0 then Rx <= Ry, else no write; done=1; go to T0.
  - NOP (111): bus = 0; no write; done=1; go to T0.
  - ALU ops (ADD/SUB/AND/SLT): bus = Rx; A <= Rx; go to T2.
- State T2:
  - Bus = Ry.
  - G <= A op Ry. ADD and SUB are modulo 2^DATA_W with no carry out.
  - AND is bitwise.
  - SLT: G = 1 if A < Ry as signed two's complement, else 0.
  - Z <= (result == 0).
  - Go to T3.
- State T3: bus = G; Rx <= G; done=1; go to T0.
- Latency (clock cycles from T0 with run=1 to done): MV/MVI/MVNZ/NOP = 2; ALU ops = 4.
- Back-to-back: run held high restarts from T0 on the cycle after done; no extra idle cycle other than T0 itself.
- run deasserted mid-instruction is ignored; the instruction completes.
- ir changes after the T0 capture are ignored; only the latched IR is used.
- Rx == Ry is legal, e.g. ADD R1,R1 doubles R1.
- Z changes only in T2 of an ALU op. MV, MVI and MVNZ leave Z unchanged.
- Reset during any state aborts the instruction immediately. There is no partial write after reset release.

Optional Feature:
- Macro PROC_FLAGS_EN.
- When defined, adds outputs n_flag, c_flag and v_flag, registered in T2 alongside Z.
  - N = result MSB.
  - C = carry out of ADD, or borrow (A < Ry unsigned) for SUB; 0 for AND/SLT.
  - V = signed overflow for ADD/SUB; 0 otherwise.
  - All three reset to 0.
- When undefined, these ports and registers do not exist. Core behaviour is otherwise identical.

Test Plan:
- Reset, then MVI R0 (ir=001000000, din=2, run=1) -> T1: q=2, done=1. R0=2 two cycles after run.
- MV R1,R0 (000001000) -> T1: q=2, done=1. R1=2.
- ADD R1,R1 (010001001):
  - T1: q=2. T2: q=2. T3: q=4, done=1.
  - R1=4, Z=0. done occurs on the 4th cycle.
- SUB R2,R0 with R2=0 (011010000) -> T3: q=16'hFFFE. Z=0.
  - With PROC_FLAGS_EN: N=1, C=1, V=0.
- Zero flag and MVNZ:
  - R3=5; SUB R3,R3 -> G=0, Z=1.
  - MVNZ R4,R0 -> R4 unchanged.
  - ADD R0,R0 -> Z=0; MVNZ R4,R0 -> R4=R0.
- DATA_W=8, NREGS=4 build (IR_W=7):
  - MVI R0,#8'hFF; MVI R1,#1; ADD R0,R1 -> R0=0, Z=1.
  - SLT R1,R0 with R0=8'h80 -> R1=0.
- Reset asserted during T2 of an ADD -> q=0, done=0, all registers 0 immediately.
  - After release, state T0; next MVI executes normally.

Source files
------------

// File: rtl/proc_param.sv
// Parametrised multi-cycle MV/MVI/ADD/SUB/AND/SLT/MVNZ core with zero flag and done strobe.
// Define PROC_FLAGS_EN to add registered N/C/V flag outputs alongside Z.
//
// state | meaning
// T0    | idle; latch IR when run is high
// T1    | single-cycle ops complete here; ALU ops load A from Rx
// T2    | ALU computes A op Ry into G; flags update
// T3    | write G back to Rx
module proc_param #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  localparam int REG_AW = $clog2(NREGS),
  localparam int IR_W   = 3 + 2*REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [IR_W-1:0]   ir,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q,
  output logic              done
`ifdef PROC_FLAGS_EN
  ,
  output logic              n_flag,
  output logic              c_flag,
  output logic              v_flag
`endif
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

`ifdef PROC_FLAGS_EN
  localparam int SUM_W = DATA_W + 1;
`else
  localparam int SUM_W = DATA_W;
`endif

  state_t              state_q, state_d;
  logic [IR_W-1:0]     ir_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   a_q, g_q;
  logic                z_q;

  logic [2:0]          op;
  logic [REG_AW-1:0]   rx, ry;
  logic [DATA_W-1:0]   rx_val, ry_val, bus, alu_res;
  logic [SUM_W-1:0]    sum_w, diff_w;
  logic                ir_ld, a_ld, g_ld, rf_we;

  assign op     = ir_q[IR_W-1 -: 3];
  assign rx     = ir_q[2*REG_AW-1 -: REG_AW];
  assign ry     = ir_q[REG_AW-1:0];
  assign rx_val = regs_q[rx];
  assign ry_val = regs_q[ry];
  assign q      = bus;

  always_comb begin
    state_d = state_q;
    bus     = '0;
    done    = 1'b0;
    ir_ld   = 1'b0;
    a_ld    = 1'b0;
    g_ld    = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      T0: begin
        if (run) begin
          ir_ld   = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        state_d = T0;
        done    = 1'b1;
        case (op)
          OP_MV:   begin bus = ry_val; rf_we = 1'b1;  end
          OP_MVI:  begin bus = din;    rf_we = 1'b1;  end
          OP_MVNZ: begin bus = ry_val; rf_we = ~z_q;  end
          OP_NOP:  ;
          default: begin
            bus     = rx_val;
            a_ld    = 1'b1;
            done    = 1'b0;
            state_d = T2;
          end
        endcase
      end
      T2: begin
        bus     = ry_val;
        g_ld    = 1'b1;
        state_d = T3;
      end
      T3: begin
        bus     = g_q;
        rf_we   = 1'b1;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
  end

  // sum/diff carry one extra bit only when the carry/borrow flag exists
  assign sum_w  = SUM_W'(a_q) + SUM_W'(ry_val);
  assign diff_w = SUM_W'(a_q) - SUM_W'(ry_val);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = sum_w[DATA_W-1:0];
      OP_SUB:  alu_res = diff_w[DATA_W-1:0];
      OP_AND:  alu_res = a_q & ry_val;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(ry_val))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      if (ir_ld) ir_q <= ir;
      if (a_ld)  a_q  <= bus;
      if (g_ld) begin
        g_q <= alu_res;
        z_q <= (alu_res == '0);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rx] <= bus;
    end
  end

`ifdef PROC_FLAGS_EN
  logic n_q, c_q, v_q, c_d, v_d;
  localparam int MSB = DATA_W - 1;

  always_comb begin
    c_d = 1'b0;
    v_d = 1'b0;
    case (op)
      OP_ADD: begin
        c_d = sum_w[DATA_W];
        v_d = (a_q[MSB] == ry_val[MSB]) && (sum_w[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        c_d = diff_w[DATA_W];
        v_d = (a_q[MSB] != ry_val[MSB]) && (diff_w[MSB] != a_q[MSB]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else if (g_ld) begin
      n_q <= alu_res[MSB];
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign n_flag = n_q;
  assign c_flag = c_q;
  assign v_flag = v_q;
`endif

endmodule

// File: tb/tb_proc_param.sv
// Randomised scoreboard bench for proc_param: an instruction-level model predicts
// the bus value and timing of every done strobe; a monitor checks them independently.
module tb_proc_param;
  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = $clog2(NREGS);
  localparam int IR_W   = 3 + 2*REG_AW;

  logic              clock = 1'b0;
  logic              reset;
  logic              run;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] q;
  logic              done;
`ifdef PROC_FLAGS_EN
  logic              n_flag, c_flag, v_flag;
`endif

  proc_param #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .ir    (ir),
    .din   (din),
    .q     (q),
    .done  (done)
`ifdef PROC_FLAGS_EN
    ,
    .n_flag(n_flag),
    .c_flag(c_flag),
    .v_flag(v_flag)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] q_fin;
    logic [DATA_W-1:0] q_t1;
    logic [DATA_W-1:0] q_t2;
    bit                alu;
    int                cyc;
    bit                n, c, v;
  } exp_t;

  exp_t sb [$];
  int checks   = 0;
  int failures = 0;

  // instruction-level reference state
  logic [DATA_W-1:0] m_regs [NREGS];
  bit m_z, m_n, m_c, m_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sval(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? longint'(x) - (longint'(1) << DATA_W) : longint'(x);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_z = 1'b1; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
  endtask

  // Called at #1 after a rising edge with the DUT idle in T0; returns in T0.
  task automatic issue(input logic [2:0] op, input int rx, input int ry, input logic [DATA_W-1:0] imm);
    exp_t e;
    logic [DATA_W-1:0] a, b, r;
    longint s, maxs, mins;
    maxs = (longint'(1) << (DATA_W-1)) - 1;
    mins = -(longint'(1) << (DATA_W-1));
    a = m_regs[rx];
    b = m_regs[ry];
    e.q_t1 = a;
    e.q_t2 = b;
    e.alu  = 1'b0;
    r      = '0;
    case (op)
      3'd0: begin e.q_fin = b;   m_regs[rx] = b;   end
      3'd1: begin e.q_fin = imm; m_regs[rx] = imm; end
      3'd6: begin e.q_fin = b; if (!m_z) m_regs[rx] = b; end
      3'd7: e.q_fin = '0;
      default: begin
        e.alu = 1'b1;
        m_c = 1'b0;
        m_v = 1'b0;
        case (op)
          3'd2: begin
            r   = a + b;
            m_c = (longint'(a) + longint'(b)) >= (longint'(1) << DATA_W);
            s   = sval(a) + sval(b);
            m_v = (s > maxs) || (s < mins);
          end
          3'd3: begin
            r   = a - b;
            m_c = (a < b);
            s   = sval(a) - sval(b);
            m_v = (s > maxs) || (s < mins);
          end
          3'd4: r = a & b;
          default: r = (sval(a) < sval(b)) ? DATA_W'(1) : DATA_W'(0);
        endcase
        m_z = (r == '0);
        m_n = r[DATA_W-1];
        m_regs[rx] = r;
        e.q_fin = r;
      end
    endcase
    e.cyc = cyc + (e.alu ? 4 : 2) - 1;
    e.n = m_n; e.c = m_c; e.v = m_v;
    sb.push_back(e);

    run = 1'b1;
    ir  = {op, REG_AW'(rx), REG_AW'(ry)};
    din = imm;
    @(posedge clock); #1;
    ir  = IR_W'($urandom);
    run = e.alu ? 1'($urandom_range(0, 1)) : 1'b0;
    if (e.alu) begin
      @(posedge clock); #1;
      din = DATA_W'($urandom);
      run = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      run = 1'b0;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    ir  = IR_W'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic readback_all();
    for (int i = 0; i < NREGS; i++) issue(3'd0, i, i, '0);
  endtask

  // monitor: checks every done strobe against the scoreboard
  logic [DATA_W-1:0] hist1 = '0, hist2 = '0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=1 expected=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("done_q", 64'(q), 64'(e.q_fin));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          if (e.alu) begin
            chk("t1_bus_rx", 64'(hist2), 64'(e.q_t1));
            chk("t2_bus_ry", 64'(hist1), 64'(e.q_t2));
          end
`ifdef PROC_FLAGS_EN
          chk("n_flag", 64'(n_flag), 64'(e.n));
          chk("c_flag", 64'(c_flag), 64'(e.c));
          chk("v_flag", 64'(v_flag), 64'(e.v));
`endif
        end
      end
      hist2 = hist1;
      hist1 = q;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, rx, ry;
    reset = 1'b1;
    run   = 1'b0;
    ir    = '0;
    din   = '0;
    model_reset();
    @(posedge clock); #1;
    chk("reset_q", 64'(q), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // MVNZ right after reset: Z=1 so no write
    issue(3'd1, 0, 0, DATA_W'(2));
    issue(3'd6, 5, 0, '0);
    issue(3'd0, 5, 5, '0);
    // directed sequence from the plan
    issue(3'd1, 0, 0, DATA_W'(2));
    issue(3'd0, 1, 0, '0);
    issue(3'd2, 1, 1, '0);
    issue(3'd3, 2, 0, '0);
    issue(3'd1, 3, 0, DATA_W'(5));
    issue(3'd3, 3, 3, '0);
    issue(3'd6, 4, 0, '0);
    issue(3'd0, 4, 4, '0);
    issue(3'd2, 0, 0, '0);
    issue(3'd6, 4, 0, '0);
    issue(3'd0, 4, 4, '0);
    issue(3'd1, 0, 0, '1);
    issue(3'd1, 1, 0, DATA_W'(1));
    issue(3'd2, 0, 1, '0);
    issue(3'd1, 0, 0, DATA_W'(1) << (DATA_W-1));
    issue(3'd5, 1, 0, '0);
    issue(3'd5, 0, 1, '0);
    issue(3'd4, 0, 1, '0);
    issue(3'd7, 2, 3, '0);
    idle(3);

    // reset in T2 of an ADD aborts with no write
    issue(3'd1, 6, 0, DATA_W'(16'h1234));
    run = 1'b1;
    ir  = {3'b010, REG_AW'(6), REG_AW'(6)};
    @(posedge clock); #1;
    run = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("abort_q", 64'(q), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    readback_all();
    issue(3'd1, 5, 0, DATA_W'($urandom));
    issue(3'd0, 5, 5, '0);

    // randomised stream with back-to-back issue and idle gaps
    for (int n = 0; n < 300; n++) begin
      k  = $urandom_range(0, 9);
      rx = $urandom_range(0, NREGS-1);
      ry = $urandom_range(0, NREGS-1);
      if (k >= 8) issue(3'd3, rx, rx, '0);
      else        issue(3'(k), rx, ry, DATA_W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    readback_all();
    idle(4);

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
